// File: rtl/prbs_if.sv
// prbs_if: word stream from the LFSR generator into the checker, with lock/error status back
interface prbs_if #(parameter int W = 5);
  logic in_valid;
  logic [W-1:0] in_data;
  logic clr;
  logic locked;
  logic err_pulse;
  logic [15:0] err_count;
  modport master(output in_valid, in_data, clr, input locked, err_pulse, err_count);
  modport slave(input in_valid, in_data, clr, output locked, err_pulse, err_count);
endinterface

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising LFSR sequence checker with lock detect; PRBS_CHK_ERR_CNT_EN builds err_count/clr
module prbs_checker #(
  parameter int W = 5,
  parameter logic [W-1:0] TAPS = 5'b10100,
  parameter int LOCK_CNT = 4,
  parameter int UNLOCK_CNT = 3
) (
  input logic clk,
  input logic rst,
  prbs_if.slave bus
);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
  state_t state, state_n;
  logic [W-1:0] pred, pred_n;
  logic [3:0] match_cnt, match_cnt_n, miss_cnt, miss_cnt_n;
  logic locked, err_pulse, v, hit, nz, miss;
  function automatic logic [W-1:0] nxt(input logic [W-1:0] x);
    return {x[W-2:0], ^(x & TAPS)};
  endfunction
  assign v = bus.in_valid;
  assign hit = bus.in_data == pred;
  assign nz = |bus.in_data;
  assign miss = v && state == LOCKED && !hit;
  assign bus.locked = locked;
  assign bus.err_pulse = err_pulse;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
      pred <= '0;
      match_cnt <= '0;
      miss_cnt <= '0;
      locked <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state <= state_n;
      pred <= pred_n;
      match_cnt <= match_cnt_n;
      miss_cnt <= miss_cnt_n;
      locked <= state_n == LOCKED;
      err_pulse <= miss;
    end
  end
  always_comb begin
    state_n = state;
    if (v)
      case (state)
        HUNT: state_n = nz ? VERIFY : HUNT;
        VERIFY: state_n = hit && match_cnt == 4'(LOCK_CNT - 1) ? LOCKED : (!hit && !nz ? HUNT : VERIFY);
        LOCKED: state_n = !hit && miss_cnt == 4'(UNLOCK_CNT - 1) ? HUNT : LOCKED;
        default: state_n = HUNT;
      endcase
  end
  // In LOCKED the prediction free-runs so a single corrupted word never reseeds it
  always_comb begin
    pred_n = pred;
    match_cnt_n = match_cnt;
    miss_cnt_n = miss_cnt;
    if (v)
      case (state)
        HUNT: begin
          pred_n = nz ? nxt(bus.in_data) : pred;
          match_cnt_n = nz ? '0 : match_cnt;
        end
        VERIFY: begin
          pred_n = hit ? nxt(pred) : (nz ? nxt(bus.in_data) : pred);
          match_cnt_n = hit ? match_cnt + 4'd1 : '0;
          miss_cnt_n = '0;
        end
        LOCKED: begin
          pred_n = nxt(pred);
          miss_cnt_n = hit ? '0 : miss_cnt + 4'd1;
        end
        default: ;
      endcase
  end
`ifdef PRBS_CHK_ERR_CNT_EN
  logic [15:0] err_count;
  always_ff @(posedge clk) begin
    if (rst) err_count <= '0;
    else if (bus.clr) err_count <= {15'd0, miss};
    else if (miss && ~&err_count) err_count <= err_count + 16'd1;
  end
  assign bus.err_count = err_count;
`else
  logic unused_clr;
  assign unused_clr = bus.clr;
  assign bus.err_count = '0;
`endif
endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: vector table, directed corner sequences and randomized run against a phase-indexed model
module tb_prbs_checker;
  localparam int W = 5, LK = 4, UL = 3;
`ifdef PRBS_CHK_ERR_CNT_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  prbs_if #(.W(W)) bus();
  prbs_checker #(.W(W)) dut(.clk(clk), .rst(rst), .bus(bus));
  logic [W-1:0] seq[31];
  int n_cmp = 0, n_bad = 0;
  int m_mode = 0, m_ph = 0, m_run = 0, m_bad = 0, m_cnt = 0;
  bit m_lk = 0, m_p = 0;
  typedef struct {bit v; logic [4:0] d; bit c; bit lk; bit p; int cnt;} vec_t;
  vec_t tv[10];

  function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] x);
    return {x[W-2:0], ^(x & 5'b10100)};
  endfunction
  function automatic int idx(input logic [W-1:0] d);
    for (int i = 0; i < 31; i++) if (seq[i] == d) return i;
    return 0;
  endfunction
  function automatic logic [W-1:0] expw();
    return seq[m_ph];
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model tracks the position in the 31-word period rather than a predicted word
  task automatic model(input bit v, input logic [W-1:0] d, input bit c);
    bit miss = 0;
    if (rst) begin
      m_mode = 0; m_run = 0; m_bad = 0; m_lk = 0; m_p = 0; m_cnt = 0;
      return;
    end
    if (v)
      case (m_mode)
        0: if (d != 0) begin m_ph = (idx(d) + 1) % 31; m_run = 0; m_mode = 1; end
        1: if (d == expw()) begin
             m_ph = (m_ph + 1) % 31; m_run++;
             if (m_run == LK) begin m_mode = 2; m_bad = 0; end
           end else if (d != 0) begin m_ph = (idx(d) + 1) % 31; m_run = 0; end
           else m_mode = 0;
        default: begin
          miss = d != expw();
          m_ph = (m_ph + 1) % 31;
          m_bad = miss ? m_bad + 1 : 0;
          if (m_bad == UL) m_mode = 0;
        end
      endcase
    m_lk = m_mode == 2;
    m_p = miss;
    if (CE) m_cnt = c ? int'(miss) : (miss && m_cnt < 65535 ? m_cnt + 1 : m_cnt);
  endtask

  task automatic step(input bit v, input logic [W-1:0] d, input bit c);
    bus.in_valid = v; bus.in_data = d; bus.clr = c;
    @(posedge clk); #1;
    model(v, d, c);
  endtask

  task automatic go(input bit v, input logic [W-1:0] d, input bit c, input string nm);
    step(v, d, c);
    chk({nm, "_locked"}, int'(bus.locked), int'(m_lk));
    chk({nm, "_pulse"}, int'(bus.err_pulse), int'(m_p));
    chk({nm, "_count"}, int'(bus.err_count), m_cnt);
  endtask

  task automatic relock(input int k, input string nm);
    for (int i = 0; i < 5; i++) go(1, seq[(k + i) % 31], 0, nm);
    chk({nm, "_relocked"}, int'(bus.locked), 1);
  endtask

`ifdef PRBS_CHK_ERR_CNT_EN
  prbs_if #(.W(W)) sbus();
  prbs_checker #(.W(W), .UNLOCK_CNT(15)) sat_dut(.clk(clk), .rst(rst), .bus(sbus));
  initial begin sbus.in_valid = 0; sbus.in_data = '0; sbus.clr = 0; end
  task automatic sat_word(input logic [W-1:0] d);
    sbus.in_data = d;
    @(posedge clk); #1;
  endtask
  task automatic run_sat();
    int ph = 5;
    sbus.in_valid = 1;
    for (int i = 0; i < 5; i++) sat_word(seq[i]);
    chk("sat_locked", int'(sbus.locked), 1);
    for (int g = 0; g < 4681; g++) begin
      for (int k = 0; k < 14; k++) begin sat_word(seq[ph] ^ 5'b00001); ph = (ph + 1) % 31; end
      sat_word(seq[ph]); ph = (ph + 1) % 31;
    end
    chk("sat_fffe", int'(sbus.err_count), 16'hFFFE);
    sat_word(seq[ph] ^ 5'b00001); ph = (ph + 1) % 31;
    chk("sat_ffff", int'(sbus.err_count), 16'hFFFF);
    sat_word(seq[ph] ^ 5'b00001);
    chk("sat_hold", int'(sbus.err_count), 16'hFFFF);
    chk("sat_still_locked", int'(sbus.locked), 1);
    sbus.in_valid = 0;
  endtask
`endif

  initial begin
    bit v, c;
    logic [W-1:0] d;
    int r;
    seq[0] = 5'b00001;
    for (int i = 1; i < 31; i++) seq[i] = lfsr_next(seq[i-1]);
    tv[0] = '{1, 5'b00001, 0, 0, 0, 0};
    tv[1] = '{1, 5'b00010, 0, 0, 0, 0};
    tv[2] = '{1, 5'b00100, 0, 0, 0, 0};
    tv[3] = '{1, 5'b01001, 0, 0, 0, 0};
    tv[4] = '{1, 5'b10010, 0, 1, 0, 0};
    tv[5] = '{1, 5'b00111, 0, 1, 1, 1};
    tv[6] = '{1, 5'b01011, 0, 1, 0, 1};
    tv[7] = '{1, 5'b10110, 0, 1, 0, 1};
    tv[8] = '{0, 5'b11111, 0, 1, 0, 1};
    tv[9] = '{1, 5'b01100, 0, 1, 0, 1};

    rst = 1;
    step(0, '0, 0);
    chk("reset_locked", int'(bus.locked), 0);
    chk("reset_pulse", int'(bus.err_pulse), 0);
    chk("reset_count", int'(bus.err_count), 0);
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      step(tv[i].v, tv[i].d, tv[i].c);
      chk($sformatf("vec%0d_locked", i), int'(bus.locked), int'(tv[i].lk));
      chk($sformatf("vec%0d_pulse", i), int'(bus.err_pulse), int'(tv[i].p));
      chk($sformatf("vec%0d_count", i), int'(bus.err_count), CE ? tv[i].cnt : 0);
    end

    for (int i = 0; i < 3; i++) go(1, expw() ^ 5'b00001, 0, "lol");
    chk("lol_unlocked", int'(bus.locked), 0);
    chk("lol_count", int'(bus.err_count), CE ? 4 : 0);
    relock(10, "lol_relock");

    for (int i = 0; i < 7; i++) go(0, 5'($urandom), 0, "gap");
    go(1, expw(), 0, "gap_resume");
    chk("gap_no_pulse", int'(bus.err_pulse), 0);
    chk("gap_locked", int'(bus.locked), 1);

    go(1, expw() ^ 5'b00001, 0, "clr_miss");
    go(1, expw(), 0, "clr_match");
    chk("clr_pre", int'(bus.err_count), CE ? 5 : 0);
    go(1, expw() ^ 5'b00001, 1, "clr_and_miss");
    chk("clr_and_miss_eq1", int'(bus.err_count), CE ? 1 : 0);
    go(0, '0, 1, "clr_alone");
    chk("clr_alone_eq0", int'(bus.err_count), 0);

    rst = 1; go(0, '0, 0, "zr_rst"); rst = 0;
    for (int i = 0; i < 40; i++) go(1, '0, 0, "zero");
    chk("zero_unlocked", int'(bus.locked), 0);
    chk("zero_count", int'(bus.err_count), 0);

    relock(3, "rml");
    go(1, expw() ^ 5'b00001, 0, "rml_miss");
    rst = 1;
    go(1, expw() ^ 5'b00001, 1, "rml_rst");
    chk("rml_locked", int'(bus.locked), 0);
    chk("rml_pulse", int'(bus.err_pulse), 0);
    chk("rml_count", int'(bus.err_count), 0);
    rst = 0;

    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 299) == 0;
      v = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 19);
      d = r < 17 ? expw() : (r < 18 ? 5'b00000 : 5'($urandom));
      c = $urandom_range(0, 63) == 0;
      go(v, d, c, "rand");
    end
    rst = 0;

`ifdef PRBS_CHK_ERR_CNT_EN
    bus.in_valid = 0;
    run_sat();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/prbs_checker.md
# prbs_checker

Downstream consumer of the 5-bit LFSR pattern generator. Samples the generator's parallel output word, self-synchronises to the sequence, and declares lock after a run of correct predictions. While locked, it flags every mismatching word and keeps an error count. It is the receive-side monitor for link and BIST tests driven by the LFSR.

## Interface
Parameters:
- W, 5, word width; must equal the generator's output width.
- TAPS, 5'b10100, feedback mask. The next word is {cur[W-2:0], ^(cur & TAPS)}. The default matches the generator (x^5+x^3+1, period 31).
- LOCK_CNT, 4, consecutive correct predictions needed to enter LOCKED (range 1..15).
- UNLOCK_CNT, 3, consecutive mismatches in LOCKED that force a return to HUNT (range 1..15).

Ports:
- clk, input, 1, single clock; all logic on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- in_valid, input, 1, in_data is sampled only when high.
- in_data, input, W, generator word (connects to the LFSR `out`).
- clr, input, 1, synchronous clear of err_count.
- locked, output, 1, registered; high in the LOCKED state.
- err_pulse, output, 1, registered; one-cycle pulse per mismatch while LOCKED.
- err_count, output, 16, registered saturating mismatch count.

## Operation
- Internal state: FSM {HUNT, VERIFY, LOCKED}; pred[W-1:0]; match_cnt[3:0]; miss_cnt[3:0].
- nxt(x) is the single LFSR step defined under TAPS.
- All state holds on any cycle with in_valid=0.
- **HUNT:** on valid nonzero in_data, set pred=nxt(in_data), match_cnt=0, and go to VERIFY. All-zero words are ignored (lock-up state); the FSM stays in HUNT.
- **VERIFY:** on valid in_data==pred, set pred=nxt(pred) and match_cnt++. On reaching LOCK_CNT, go to LOCKED with miss_cnt=0.
- **VERIFY mismatch:** if in_data is nonzero, reseed (pred=nxt(in_data), match_cnt=0) and stay in VERIFY. If in_data is zero, go to HUNT.
- No errors are counted outside LOCKED.
- **LOCKED match:** pred=nxt(pred), miss_cnt=0.
- **LOCKED mismatch:** pred=nxt(pred), so prediction free-runs and a single bad word does not propagate. Assert err_pulse next cycle, increment err_count, miss_cnt++. When miss_cnt reaches UNLOCK_CNT, go to HUNT and drop locked.
- **err_count:** saturates at 16'hFFFF.
- **clr:** clr alone gives err_count=0. clr together with a counted mismatch in the same cycle gives err_count=1 (clear, then count).
- **Reset:** state=HUNT; pred, match_cnt, miss_cnt=0; locked=0; err_pulse=0; err_count=0. Reset mid-lock takes effect at the next edge regardless of in_valid, clr or pending errors.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Sampling the seed word takes one edge (HUNT to VERIFY).
- locked rises on the edge that samples the LOCK_CNT-th correct word after the seed. With defaults, the 5th consecutive valid word of a clean sequence.
- err_pulse and err_count update on the same edge that samples the bad word. err_pulse is high for exactly one cycle per bad word, including back-to-back bad words.
- locked falls on the edge that samples the UNLOCK_CNT-th consecutive bad word. That word still pulses err_pulse and is counted.
- Throughput: one word per cycle; in_valid may toggle arbitrarily.

## Configuration
- Macro: PRBS_CHK_ERR_CNT_EN.
- **Defined:** the 16-bit saturating err_count register and the clr logic are built as described.
- **Undefined:** err_count is tied to 16'h0000 and clr is ignored. locked, err_pulse and the FSM are unchanged.

## Test plan
- **Clean lock:** after reset, feed valid 00001, 00010, 00100, 01001, 10010 -> locked=1 after the 5th edge; err_pulse never asserts; err_count=0.
- **Single error:** while locked, expected word 00101, send 00111, then 01011 -> one err_pulse, err_count=1, locked stays 1, and 01011 is accepted as a match.
- **Loss of lock:** while locked, send three consecutive wrong words -> three err_pulses, err_count=3, locked=0 on the 3rd edge; a subsequent clean 5-word run relocks.
- **Zero / invalid input:** hold in_data=00000 with in_valid=1 for 40 cycles -> locked=0, err_count=0. While locked, drop in_valid for 7 cycles -> no state change, and the next expected word still matches.
- **clr and saturation:** with err_count=5, assert clr together with a mismatch -> err_count=1. Preload to 16'hFFFE via errors and force two more -> count holds at 16'hFFFF. Repeat with PRBS_CHK_ERR_CNT_EN undefined -> err_count stays 0.
- **Reset mid-lock:** assert rst for 1 cycle while locked with an error pending -> next edge locked=0, err_pulse=0, err_count=0, state HUNT.
